memory_port_arbiter: RTL and testbench

Shares the CPU's single block-RAM port between two requesters: the CPU datapath (instruction fetch, load, store) and the display scan-out engine (read-only character/pixel fetch). It arbitrates each cycle, steers address, write data and write enable to the memory, and returns read data to whichever requester issued the read. The CPU has priority. A starvation counter guarantees the display a slot within a bounded number of cycles unless the CPU holds the port locked.

---
 rtl/memory_port_arbiter.sv | 72 +++++++
 tb/tb_memory_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one block-RAM port between the CPU and display scan-out, CPU first with bounded display starvation
module memory_port_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_request,
    input  logic                     cpu_write,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0]    cpu_write_data,
    input  logic                     cpu_lock,
    output logic                     cpu_grant,
    output logic                     cpu_read_valid,
    output logic [DATA_WIDTH-1:0]    cpu_read_data,
    input  logic                     display_request,
    input  logic [ADDRESS_WIDTH-1:0] display_address,
    output logic                     display_grant,
    output logic                     display_read_valid,
    output logic [DATA_WIDTH-1:0]    display_read_data,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic [DATA_WIDTH-1:0]    memory_write_data,
    output logic                     memory_write_enable,
    input  logic [DATA_WIDTH-1:0]    memory_read_data
);
    typedef enum logic {CPU_PRIORITY, DISPLAY_FORCED} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t state_q, state_d;
    logic [3:0] starve_q, starve_d, starve_inc;
    logic [1:0] tag_q, tag_d;
    logic display_win;
    // arbitration, port steering, starvation tracking and read-owner tag
    always_comb begin
        display_win = display_request & ~cpu_lock & ((state_q == DISPLAY_FORCED) | ~cpu_request);
        display_grant = display_win & ~reset;
        cpu_grant = cpu_request & ~display_win & ~reset;
        memory_address = display_grant ? display_address : cpu_address;
        memory_write_data = cpu_write_data;
        memory_write_enable = cpu_grant & cpu_write;
        tag_d = {(cpu_grant & ~cpu_write) | display_grant, display_grant};
        starve_inc = starve_q + 4'd1;
        state_d = CPU_PRIORITY;
        starve_d = starve_q;
        if (!cpu_lock) begin
            if (display_grant || !display_request) starve_d = 4'd0;
            else if (starve_inc >= LIMIT) begin
                starve_d = 4'd0;
                state_d = DISPLAY_FORCED;
            end else starve_d = starve_inc;
        end
    end
    // read returns go to whichever requester owned the read one cycle earlier
    always_comb begin
        cpu_read_valid = tag_q[1] & ~tag_q[0] & ~reset;
        display_read_valid = tag_q[1] & tag_q[0] & ~reset;
        cpu_read_data = memory_read_data;
        display_read_data = memory_read_data;
    end
    // state, starvation counter and tag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CPU_PRIORITY;
            starve_q <= 4'd0;
            tag_q <= 2'b00;
        end else begin
            state_q <= state_d;
            starve_q <= starve_d;
            tag_q <= tag_d;
        end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed-vector bench for memory_port_arbiter with a registered-read RAM model
module tb_memory_port_arbiter;
    logic clock, reset;
    logic cpu_request, cpu_write, cpu_lock, cpu_grant, cpu_read_valid;
    logic [15:0] cpu_address, cpu_write_data, cpu_read_data;
    logic display_request, display_grant, display_read_valid;
    logic [15:0] display_address, display_read_data;
    logic [15:0] memory_address, memory_write_data, memory_read_data;
    logic memory_write_enable;
    logic [15:0] mem [256];
    int tests = 0, fails = 0;

    memory_port_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_request(cpu_request), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_write_data(cpu_write_data), .cpu_lock(cpu_lock), .cpu_grant(cpu_grant),
        .cpu_read_valid(cpu_read_valid), .cpu_read_data(cpu_read_data),
        .display_request(display_request), .display_address(display_address),
        .display_grant(display_grant), .display_read_valid(display_read_valid),
        .display_read_data(display_read_data),
        .memory_address(memory_address), .memory_write_data(memory_write_data),
        .memory_write_enable(memory_write_enable), .memory_read_data(memory_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // registered-read RAM: data valid the cycle after the address is sampled
    always @(posedge clock) begin
        if (memory_write_enable) mem[memory_address[7:0]] <= memory_write_data;
        memory_read_data <= mem[memory_address[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic cg, input logic dg, input logic we,
                        input logic [15:0] addr, input logic cv, input logic dv, input logic [15:0] data);
        @(negedge clock);
        check({tag, ".cpu_grant"}, 32'(cpu_grant), 32'(cg));
        check({tag, ".display_grant"}, 32'(display_grant), 32'(dg));
        check({tag, ".write_enable"}, 32'(memory_write_enable), 32'(we));
        check({tag, ".address"}, 32'(memory_address), 32'(addr));
        check({tag, ".cpu_read_valid"}, 32'(cpu_read_valid), 32'(cv));
        check({tag, ".display_read_valid"}, 32'(display_read_valid), 32'(dv));
        if (cv) check({tag, ".cpu_read_data"}, 32'(cpu_read_data), 32'(data));
        if (dv) check({tag, ".display_read_data"}, 32'(display_read_data), 32'(data));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h30] = 16'h3333;
        mem[8'h40] = 16'h4444;
        reset = 1'b1;
        cpu_request = 1'b1; cpu_write = 1'b1; cpu_address = 16'h00FF; cpu_write_data = 16'h0000;
        cpu_lock = 1'b0; display_request = 1'b1; display_address = 16'h0040;
        step("rst0", 0, 0, 0, 16'h00FF, 0, 0, 0);
        step("rst1", 0, 0, 0, 16'h00FF, 0, 0, 0);
        reset = 1'b0;
        step("rel", 1, 0, 1, 16'h00FF, 0, 0, 0);
        cpu_request = 1'b0; display_request = 1'b0;
        step("idle", 0, 0, 0, 16'h00FF, 0, 0, 0);

        cpu_request = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0010;
        step("rd", 1, 0, 0, 16'h0010, 0, 0, 0);
        cpu_request = 1'b0;
        step("rd_ret", 0, 0, 0, 16'h0010, 1, 0, 16'hBEEF);

        cpu_request = 1'b1; cpu_write = 1'b1; cpu_address = 16'h0020; cpu_write_data = 16'h1234;
        #1 check("wr.write_data", 32'(memory_write_data), 32'h1234);
        step("wr", 1, 0, 1, 16'h0020, 0, 0, 0);
        cpu_request = 1'b0; cpu_write = 1'b0;
        step("wr_done", 0, 0, 0, 16'h0020, 0, 0, 0);
        cpu_request = 1'b1;
        step("rd2", 1, 0, 0, 16'h0020, 0, 0, 0);
        cpu_request = 1'b0;
        step("rd2_ret", 0, 0, 0, 16'h0020, 1, 0, 16'h1234);

        cpu_request = 1'b1; cpu_address = 16'h0030; display_request = 1'b1; display_address = 16'h0040;
        for (int i = 0; i < 10; i++) begin
            logic d, pd;
            d = (i == 4) || (i == 9);
            pd = (i == 5);
            step($sformatf("starve%0d", i), !d, d, 0, d ? 16'h0040 : 16'h0030,
                 (i > 0) && !pd, pd, pd ? 16'h4444 : 16'h3333);
        end
        cpu_request = 1'b0; display_request = 1'b0;
        step("starve_end", 0, 0, 0, 16'h0030, 0, 1, 16'h4444);

        cpu_request = 1'b1; display_request = 1'b1;
        step("pre_lock0", 1, 0, 0, 16'h0030, 0, 0, 0);
        step("pre_lock1", 1, 0, 0, 16'h0030, 1, 0, 16'h3333);
        cpu_lock = 1'b1;
        for (int i = 0; i < 10; i++) step($sformatf("lock%0d", i), 1, 0, 0, 16'h0030, 1, 0, 16'h3333);
        cpu_lock = 1'b0;
        step("unlock0", 1, 0, 0, 16'h0030, 1, 0, 16'h3333);
        step("unlock1", 1, 0, 0, 16'h0030, 1, 0, 16'h3333);
        step("unlock2", 0, 1, 0, 16'h0040, 1, 0, 16'h3333);
        cpu_request = 1'b0; display_request = 1'b0;
        step("unlock_end", 0, 0, 0, 16'h0030, 0, 1, 16'h4444);

        cpu_request = 1'b1; display_request = 1'b1;
        step("fl0", 1, 0, 0, 16'h0030, 0, 0, 0);
        for (int i = 1; i < 4; i++) step($sformatf("fl%0d", i), 1, 0, 0, 16'h0030, 1, 0, 16'h3333);
        cpu_lock = 1'b1;
        step("forced_locked", 1, 0, 0, 16'h0030, 1, 0, 16'h3333);
        cpu_lock = 1'b0;
        for (int i = 0; i < 4; i++) step($sformatf("after_fl%0d", i), 1, 0, 0, 16'h0030, 1, 0, 16'h3333);
        step("after_fl_disp", 0, 1, 0, 16'h0040, 1, 0, 16'h3333);
        cpu_request = 1'b0; display_request = 1'b0;
        step("after_fl_end", 0, 0, 0, 16'h0030, 0, 1, 16'h4444);

        cpu_request = 1'b1; display_request = 1'b1; cpu_address = 16'h0010;
        step("mr0", 1, 0, 0, 16'h0010, 0, 0, 0);
        for (int i = 1; i < 4; i++) step($sformatf("mr%0d", i), 1, 0, 0, 16'h0010, 1, 0, 16'hBEEF);
        reset = 1'b1;
        step("mr_reset", 0, 0, 0, 16'h0010, 0, 0, 0);
        reset = 1'b0;
        step("mr_rel0", 1, 0, 0, 16'h0010, 0, 0, 0);
        for (int i = 1; i < 4; i++) step($sformatf("mr_rel%0d", i), 1, 0, 0, 16'h0010, 1, 0, 16'hBEEF);
        step("mr_disp", 0, 1, 0, 16'h0040, 1, 0, 16'hBEEF);
        cpu_request = 1'b0; display_request = 1'b0;
        step("mr_end", 0, 0, 0, 16'h0010, 0, 1, 16'h4444);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
